// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational fp32 adder among N requesters.
// A round-robin arbiter issues at most one operand pair per cycle. The adder
// sum is captured in a single-entry response register tagged with the
// requester index. A full register that is not being drained blocks new grants.
module fp_add_arbiter #(
  parameter int N    = 4,
  parameter int IDW  = (N > 1) ? $clog2(N) : 1,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_result,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q;
  logic [31:0]     rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [CNTW-1:0] op_count_q;

  logic            found;
  logic [IDW-1:0]  winner;
  logic            can_issue;
  logic            grant;
  logic [IDW-1:0]  next_ptr;

  // Round-robin search: first valid requester starting at rr_ptr_q.
  always_comb begin : pick_winner
    logic [IDW-1:0] idx;
    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % N);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // A new pair may issue when the response slot is empty or being drained now.
  assign can_issue = (state_q == EMPTY) || rsp_ready;
  assign grant     = can_issue && found;
  assign next_ptr  = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);

  // Steer the winner's operands to the shared adder; zero when nobody asks.
  always_comb begin : operand_mux
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < N; i++) begin
      if (found && (winner == IDW'(i))) begin
        add_a = req_a[32*i +: 32];
        add_b = req_b[32*i +: 32];
      end
    end
  end

  // One-hot acceptance strobe back to the winning requester.
  always_comb begin : ready_decode
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = grant && (winner == IDW'(i));
    end
  end

  // Response slot FSM, result capture, arbitration pointer and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if ((state_q == FULL) && rsp_ready) begin
        op_count_q <= op_count_q + CNTW'(1);
      end
      case (state_q)
        EMPTY: begin
          if (grant) begin
            state_q    <= FULL;
            rsp_data_q <= add_result;
            rsp_id_q   <= winner;
            rr_ptr_q   <= next_ptr;
          end
        end
        FULL: begin
          if (grant) begin
            // Drain and refill on the same edge: no bubble.
            rsp_data_q <= add_result;
            rsp_id_q   <= winner;
            rr_ptr_q   <= next_ptr;
          end else if (rsp_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = rsp_valid || (|req_valid);

endmodule
